// File: rtl/pu_sequencer.sv
// Streaming operand/result sequencer for the ProcessUnit: gathers LANES (x, w)
// beats into the lane registers, strobes the PU load phases, returns its result.
module pu_sequencer #(
  parameter int LANES = 4,
  parameter int DW    = 5,
  parameter int CW    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW-1:0]             in_x,
  input  logic [DW-1:0]             in_w,
  output logic [LANES-1:0][DW-1:0]  pu_x,
  output logic [LANES-1:0][DW-1:0]  pu_w,
  output logic                      pu_ld_mult,
  output logic                      pu_ld_sum,
  input  logic [DW-1:0]             pu_out,
  input  logic                      pu_s,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DW-1:0]             res_data,
  output logic                      res_nz,
  output logic [CW-1:0]             vec_cnt,
  output logic                      busy
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_MULT,
    S_SUM,
    S_CAPT,
    S_HOLD
  } state_e;

  state_e                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [LANES-1:0][DW-1:0]  pu_x_q, pu_x_d;
  logic [LANES-1:0][DW-1:0]  pu_w_q, pu_w_d;
  logic                      ld_mult_q, ld_mult_d;
  logic                      ld_sum_q, ld_sum_d;
  logic [DW-1:0]             res_data_q, res_data_d;
  logic                      res_nz_q, res_nz_d;
  logic [CW-1:0]             vec_cnt_q, vec_cnt_d;
  logic                      accept;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pu_x_d     = pu_x_q;
    pu_w_d     = pu_w_q;
    res_data_d = res_data_q;
    res_nz_d   = res_nz_q;
    vec_cnt_d  = vec_cnt_q;
    in_ready   = (state_q == S_IDLE) || (state_q == S_FILL);
    accept     = in_valid && in_ready;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          pu_x_d[0] = in_x;
          pu_w_d[0] = in_w;
          idx_d     = IW'(1);
          state_d   = S_FILL;
        end
      end
      S_FILL: begin
        if (accept) begin
          pu_x_d[idx_q] = in_x;
          pu_w_d[idx_q] = in_w;
          if (idx_q == IW'(LANES - 1)) begin
            idx_d   = '0;
            state_d = S_MULT;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_MULT: state_d = S_SUM;
      S_SUM:  state_d = S_CAPT;
      S_CAPT: begin
        res_data_d = pu_out;
        res_nz_d   = pu_s;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) begin
          vec_cnt_d = vec_cnt_q + CW'(1);
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes come straight from flops so they cannot glitch on state decode.
    ld_mult_d = (state_d == S_MULT);
    ld_sum_d  = (state_d == S_SUM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      pu_x_q     <= '0;
      pu_w_q     <= '0;
      ld_mult_q  <= 1'b0;
      ld_sum_q   <= 1'b0;
      res_data_q <= '0;
      res_nz_q   <= 1'b0;
      vec_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pu_x_q     <= pu_x_d;
      pu_w_q     <= pu_w_d;
      ld_mult_q  <= ld_mult_d;
      ld_sum_q   <= ld_sum_d;
      res_data_q <= res_data_d;
      res_nz_q   <= res_nz_d;
      vec_cnt_q  <= vec_cnt_d;
    end
  end

  assign pu_x       = pu_x_q;
  assign pu_w       = pu_w_q;
  assign pu_ld_mult = ld_mult_q;
  assign pu_ld_sum  = ld_sum_q;
  assign res_valid  = (state_q == S_HOLD);
  assign res_data   = res_data_q;
  assign res_nz     = res_nz_q;
  assign vec_cnt    = vec_cnt_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_pu_sequencer.sv
// Bench for pu_sequencer: a behavioural ProcessUnit closes the loop, expected
// results are queued when a vector is issued and popped when res_valid appears.
module tb_pu_sequencer;
  localparam int LANES = 4;
  localparam int DW    = 5;
  localparam int CW    = 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [DW-1:0]            in_x = '0;
  logic [DW-1:0]            in_w = '0;
  logic [LANES-1:0][DW-1:0] pu_x;
  logic [LANES-1:0][DW-1:0] pu_w;
  logic                     pu_ld_mult;
  logic                     pu_ld_sum;
  logic [DW-1:0]            pu_out;
  logic                     pu_s;
  logic                     res_valid;
  logic                     res_ready = 1'b1;
  logic [DW-1:0]            res_data;
  logic                     res_nz;
  logic [CW-1:0]            vec_cnt;
  logic                     busy;

  pu_sequencer #(.LANES(LANES), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .pu_x(pu_x), .pu_w(pu_w), .pu_ld_mult(pu_ld_mult), .pu_ld_sum(pu_ld_sum),
    .pu_out(pu_out), .pu_s(pu_s),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_nz(res_nz),
    .vec_cnt(vec_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ProcessUnit: registered products, registered sum, ReLU >>3 saturating output.
  logic signed [2*DW-1:0] prod_q [LANES];
  logic signed [2*DW+1:0] sum_q;
  logic signed [2*DW+1:0] sum_sh;
  always @(posedge clk) begin
    if (pu_ld_mult)
      for (int i = 0; i < LANES; i++) prod_q[i] <= $signed(pu_x[i]) * $signed(pu_w[i]);
    if (pu_ld_sum) sum_q <= prod_q[0] + prod_q[1] + prod_q[2] + prod_q[3];
  end
  always_comb begin
    sum_sh = sum_q >>> 3;
    if (sum_q < 0)       pu_out = '0;
    else if (sum_sh > 31) pu_out = 5'd31;
    else                  pu_out = sum_sh[DW-1:0];
    pu_s = (pu_out != '0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          nz;
  } exp_t;

  exp_t                 sb[$];
  int                   n_vec = 0;
  int                   n_err = 0;
  logic signed [DW-1:0] vx [LANES];
  logic signed [DW-1:0] vw [LANES];
  int                   gaps [LANES];
  int                   hold = 0;
  bit                   keep_valid = 1'b0;
  bit                   chk_period = 1'b0;
  int                   last_e = -1;
  logic [CW-1:0]        exp_cnt = '0;

  function automatic exp_t ref_result();
    int   s;
    exp_t r;
    s = 0;
    for (int i = 0; i < LANES; i++) s += int'(vx[i]) * int'(vw[i]);
    if (s < 0) s = 0;
    s = s / 8;
    if (s > 31) s = 31;
    r.d  = s[DW-1:0];
    r.nz = (s != 0);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    res_ready = 1'b1;
    #2 rst = 1'b0;
    step();
    #2 rst = 1'b1;
    step();
    exp_cnt = '0;
    sb.delete();
    last_e = -1;
  endtask

  task automatic beat(input int i);
    int unsigned guard;
    if (gaps[i] > 0) begin
      in_valid = 1'b0;
      repeat (gaps[i]) step();
    end
    in_valid = 1'b1;
    in_x = vx[i];
    in_w = vw[i];
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL beat_ready lane %0d: in_ready=%b, want 1", i, in_ready);
    end
    step();
    n_vec++;
    if (pu_x[i] !== vx[i] || pu_w[i] !== vw[i]) begin
      n_err++;
      $display("FAIL lane_write lane %0d: x=%h w=%h, want x=%h w=%h", i, pu_x[i], pu_w[i], vx[i], vw[i]);
    end
    if (i == LANES - 1 && keep_valid) begin
      in_x = ~vx[0];
      in_w = ~vw[0];
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic finish_vector();
    int                       e;
    exp_t                     ex;
    logic [LANES-1:0][DW-1:0] ex_x;
    logic [LANES-1:0][DW-1:0] ex_w;
    for (int i = 0; i < LANES; i++) begin
      ex_x[i] = vx[i];
      ex_w[i] = vw[i];
    end
    e = cyc;
    sb.push_back(ref_result());
    n_vec++;
    if ({pu_ld_mult, pu_ld_sum, in_ready, busy} !== 4'b1001) begin
      n_err++;
      $display("FAIL e1_strobes: mult/sum/ready/busy=%b, want 1001", {pu_ld_mult, pu_ld_sum, in_ready, busy});
    end
    if (chk_period && last_e >= 0) begin
      n_vec++;
      if (e - last_e != LANES + 4) begin
        n_err++;
        $display("FAIL vec_period: %0d cycles, want %0d", e - last_e, LANES + 4);
      end
    end
    last_e = e;
    step();
    n_vec++;
    if ({pu_ld_mult, pu_ld_sum} !== 2'b01 || pu_x !== ex_x || pu_w !== ex_w) begin
      n_err++;
      $display("FAIL e2_sum_lanes: mult/sum=%b x=%h w=%h, want 01 x=%h w=%h",
               {pu_ld_mult, pu_ld_sum}, pu_x, pu_w, ex_x, ex_w);
    end
    step();
    n_vec++;
    if ({pu_ld_mult, pu_ld_sum, res_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL e3_capt: mult/sum/valid=%b, want 000", {pu_ld_mult, pu_ld_sum, res_valid});
    end
    step();
    n_vec++;
    if (res_valid !== 1'b1) begin
      n_err++;
      $display("FAIL e4_res_valid: res_valid=%b, want 1", res_valid);
    end else begin
      ex = sb.pop_front();
      n_vec++;
      if (res_data !== ex.d || res_nz !== ex.nz || pu_x !== ex_x) begin
        n_err++;
        $display("FAIL result: data=%0d nz=%b x=%h, want data=%0d nz=%b x=%h",
                 res_data, res_nz, pu_x, ex.d, ex.nz, ex_x);
      end
      for (int k = 1; k < hold; k++) begin
        step();
        n_vec++;
        if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_data !== ex.d || res_nz !== ex.nz) begin
          n_err++;
          $display("FAIL hold cyc %0d: valid=%b ready=%b data=%0d nz=%b, want 1 0 %0d %b",
                   k, res_valid, in_ready, res_data, res_nz, ex.d, ex.nz);
        end
      end
    end
    res_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + CW'(1);
    n_vec++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || vec_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL handshake: valid=%b ready=%b cnt=%0d, want 0 1 %0d", res_valid, in_ready, vec_cnt, exp_cnt);
    end
  endtask

  task automatic drive_vector();
    res_ready = (hold == 0);
    for (int i = 0; i < LANES; i++) beat(i);
    finish_vector();
  endtask

  task automatic test_reset();
    gaps = '{0, 0, 0, 0};
    step();
    step();
    n_vec++;
    if ({pu_ld_mult, pu_ld_sum, res_valid, res_data, res_nz, vec_cnt, busy, in_ready} !== {{(DW+CW+5){1'b0}}, 1'b1}
        || pu_x !== '0 || pu_w !== '0) begin
      n_err++;
      $display("FAIL reset_initial: mult=%b sum=%b valid=%b data=%0d nz=%b cnt=%0d busy=%b ready=%b x=%h w=%h",
               pu_ld_mult, pu_ld_sum, res_valid, res_data, res_nz, vec_cnt, busy, in_ready, pu_x, pu_w);
    end
    #2 rst = 1'b1;
    step();
    vx = '{3, 1, 2, 7};
    vw = '{1, 6, -5, 2};
    beat(0);
    beat(1);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({pu_ld_mult, pu_ld_sum, res_valid, res_data, res_nz, vec_cnt, busy, in_ready} !== {{(DW+CW+5){1'b0}}, 1'b1}
        || pu_x !== '0 || pu_w !== '0) begin
      n_err++;
      $display("FAIL reset_midfill: mult=%b sum=%b valid=%b busy=%b ready=%b x=%h w=%h",
               pu_ld_mult, pu_ld_sum, res_valid, busy, in_ready, pu_x, pu_w);
    end
    in_valid = 1'b1;
    step();
    n_vec++;
    if ({pu_ld_mult, pu_ld_sum, busy} !== 3'b000 || pu_x !== '0) begin
      n_err++;
      $display("FAIL reset_held: mult/sum/busy=%b x=%h, want 000 x=0", {pu_ld_mult, pu_ld_sum, busy}, pu_x);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    step();
    exp_cnt = '0;
    vx = '{5, -3, 6, 1};
    vw = '{2, 4, 1, -7};
    drive_vector();
  endtask

  task automatic test_basic();
    apply_reset();
    gaps = '{0, 0, 0, 0};
    vx = '{4, 0, 0, 0};
    vw = '{4, 0, 0, 0};
    drive_vector();
    n_vec++;
    if (vec_cnt !== 8'd1 || res_data !== 5'd2 || res_nz !== 1'b1) begin
      n_err++;
      $display("FAIL basic_final: cnt=%0d data=%0d nz=%b, want 1 2 1", vec_cnt, res_data, res_nz);
    end
  endtask

  task automatic test_negative();
    gaps = '{0, 0, 0, 0};
    vx = '{-4, -4, -4, -4};
    vw = '{5, 5, 5, 5};
    drive_vector();
  endtask

  task automatic test_backpressure();
    gaps = '{0, 0, 0, 0};
    vx = '{7, 7, -2, 3};
    vw = '{2, 1, 5, 6};
    hold = 10;
    keep_valid = 1'b1;
    drive_vector();
    in_valid = 1'b0;
    keep_valid = 1'b0;
    hold = 0;
    step();
    n_vec++;
    if (vec_cnt !== exp_cnt || res_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_handshake: cnt=%0d valid=%b busy=%b, want %0d 0 0", vec_cnt, res_valid, busy, exp_cnt);
    end
  endtask

  task automatic test_gaps();
    gaps = '{0, 1, 3, 0};
    vx = '{1, 2, 3, 4};
    vw = '{4, 3, 2, 1};
    drive_vector();
    gaps = '{0, 0, 0, 0};
  endtask

  task automatic test_counter_wrap();
    bit saw_wrap;
    saw_wrap = 1'b0;
    chk_period = 1'b1;
    keep_valid = 1'b1;
    last_e = -1;
    for (int v = 0; v < 256; v++) begin
      for (int i = 0; i < LANES; i++) begin
        vx[i] = DW'($urandom);
        vw[i] = DW'($urandom);
      end
      drive_vector();
      if (vec_cnt === '0) saw_wrap = 1'b1;
    end
    n_vec++;
    if (!saw_wrap) begin
      n_err++;
      $display("FAIL cnt_wrap: vec_cnt never returned to 0, last=%0d", vec_cnt);
    end
    keep_valid = 1'b0;
    chk_period = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_gaps();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
